// File: rtl/operand_fetch_pkg.sv
// ============================================================================
// Module      : operand_fetch_pkg
// Description : Shared core types and opcode constants for decode/ALU stages.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package operand_fetch_pkg;

    typedef logic [2:0] Funct3_t;
    typedef logic [6:0] Funct7_t;
    typedef logic [4:0] RegIndex_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

endpackage

`default_nettype wire

// File: rtl/operand_fetch_register_file.sv
// ============================================================================
// Module      : register_file
// Description : 31x32 integer register file, two async reads, one sync write.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module register_file
    import operand_fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        wrEnable_i,
    input  RegIndex_t   wrAddr_i,
    input  logic [31:0] wrData_i,
    input  RegIndex_t   rdAddrA_i,
    output logic [31:0] rdDataA_o,
    input  RegIndex_t   rdAddrB_i,
    output logic [31:0] rdDataB_o
);

    // x0 has no storage; it is synthesised as a constant zero on the read side.
    logic [31:0] regs_q [1:31];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrEnable_i && (wrAddr_i != '0)) begin
            regs_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdDataA_o = (rdAddrA_i == '0) ? 32'd0 : regs_q[rdAddrA_i];
    assign rdDataB_o = (rdAddrB_i == '0) ? 32'd0 : regs_q[rdAddrB_i];

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module      : operand_fetch
// Description : OP/OP-IMM decode and operand read with a single-entry output stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] instruction,
    output logic        outValid,
    input  logic        outReady,
    output Funct3_t     funct3,
    output Funct7_t     funct7,
    output logic        opImm,
    output logic [31:0] rs1,
    output logic [31:0] rs2,
    output logic [31:0] immediateI,
    output logic [4:0]  rdAddr,
    output logic        illegal,
    input  logic        wbEnable,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData
);

    logic        outValid_q, outValid_d;
    Funct3_t     funct3_q,   funct3_d;
    Funct7_t     funct7_q,   funct7_d;
    logic        opImm_q,    opImm_d;
    logic [31:0] rs1_q,      rs1_d;
    logic [31:0] rs2_q,      rs2_d;
    logic [31:0] imm_q,      imm_d;
    RegIndex_t   rdAddr_q,   rdAddr_d;
    logic        illegal_q,  illegal_d;
    RegIndex_t   rs1Idx_q,   rs1Idx_d;
    RegIndex_t   rs2Idx_q,   rs2Idx_d;

    logic        accept;
    logic        wbLive;
    RegIndex_t   decRs1Idx;
    RegIndex_t   decRs2Idx;
    logic [6:0]  decOpcode;
    logic [31:0] arrRs1;
    logic [31:0] arrRs2;
    logic [31:0] fetchRs1;
    logic [31:0] fetchRs2;

    assign decRs1Idx = instruction[19:15];
    assign decRs2Idx = instruction[24:20];
    assign decOpcode = instruction[6:0];

    register_file u_register_file (
        .clock      (clock),
        .reset      (reset),
        .wrEnable_i (wbEnable),
        .wrAddr_i   (wbAddr),
        .wrData_i   (wbData),
        .rdAddrA_i  (decRs1Idx),
        .rdDataA_o  (arrRs1),
        .rdAddrB_i  (decRs2Idx),
        .rdDataB_o  (arrRs2)
    );

    assign inReady = !outValid_q || outReady;
    assign accept  = inValid && inReady;
    // A writeback to x0 never forwards, so the zero register stays zero everywhere.
    assign wbLive  = BYPASS_EN && wbEnable && (wbAddr != '0);

    assign fetchRs1 = (wbLive && (wbAddr == decRs1Idx)) ? wbData : arrRs1;
    assign fetchRs2 = (wbLive && (wbAddr == decRs2Idx)) ? wbData : arrRs2;

    always_comb begin
        outValid_d = outValid_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        opImm_d    = opImm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        rdAddr_d   = rdAddr_q;
        illegal_d  = illegal_q;
        rs1Idx_d   = rs1Idx_q;
        rs2Idx_d   = rs2Idx_q;

        if (accept) begin
            outValid_d = 1'b1;
            funct3_d   = instruction[14:12];
            funct7_d   = instruction[31:25];
            opImm_d    = (decOpcode == OPCODE_OP_IMM);
            rs1_d      = fetchRs1;
            rs2_d      = fetchRs2;
            imm_d      = {{20{instruction[31]}}, instruction[31:20]};
            rdAddr_d   = instruction[11:7];
            illegal_d  = (decOpcode != OPCODE_OP) && (decOpcode != OPCODE_OP_IMM);
            rs1Idx_d   = decRs1Idx;
            rs2Idx_d   = decRs2Idx;
        end else if (outReady) begin
            outValid_d = 1'b0;
        end else if (outValid_q) begin
            // Stalled instruction picks up results that retire while it waits.
            if (wbLive && (wbAddr == rs1Idx_q)) begin
                rs1_d = wbData;
            end
            if (wbLive && (wbAddr == rs2Idx_q)) begin
                rs2_d = wbData;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outValid_q <= 1'b0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            opImm_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            rdAddr_q   <= '0;
            illegal_q  <= 1'b0;
            rs1Idx_q   <= '0;
            rs2Idx_q   <= '0;
        end else begin
            outValid_q <= outValid_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
            opImm_q    <= opImm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
            rdAddr_q   <= rdAddr_d;
            illegal_q  <= illegal_d;
            rs1Idx_q   <= rs1Idx_d;
            rs2Idx_q   <= rs2Idx_d;
        end
    end

    assign outValid   = outValid_q;
    assign funct3     = funct3_q;
    assign funct7     = funct7_q;
    assign opImm      = opImm_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign immediateI = imm_q;
    assign rdAddr     = rdAddr_q;
    assign illegal    = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module      : tb_operand_fetch
// Description : Scoreboard bench for operand_fetch, with and without bypass.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        in_ready,  in_ready0;
    logic        out_valid, out_valid0;
    logic [2:0]  f3,  f3_0;
    logic [6:0]  f7,  f7_0;
    logic        opi, opi0;
    logic [31:0] r1,  r1_0;
    logic [31:0] r2,  r2_0;
    logic [31:0] imm, imm0;
    logic [4:0]  rd,  rd0;
    logic        ill, ill0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    operand_fetch #(.BYPASS_EN(1'b1)) dut (
        .clock(clk), .reset(rst), .inValid(in_valid), .inReady(in_ready),
        .instruction(instr), .outValid(out_valid), .outReady(out_ready),
        .funct3(f3), .funct7(f7), .opImm(opi), .rs1(r1), .rs2(r2),
        .immediateI(imm), .rdAddr(rd), .illegal(ill),
        .wbEnable(wb_en), .wbAddr(wb_addr), .wbData(wb_data)
    );

    operand_fetch #(.BYPASS_EN(1'b0)) dut_nobyp (
        .clock(clk), .reset(rst), .inValid(in_valid), .inReady(in_ready0),
        .instruction(instr), .outValid(out_valid0), .outReady(out_ready),
        .funct3(f3_0), .funct7(f7_0), .opImm(opi0), .rs1(r1_0), .rs2(r2_0),
        .immediateI(imm0), .rdAddr(rd0), .illegal(ill0),
        .wbEnable(wb_en), .wbAddr(wb_addr), .wbData(wb_data)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        opi;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ill;
        logic [4:0]  i1;
        logic [4:0]  i2;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:31];

    // Reference model for the bypass-enabled instance; sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            for (int i = 0; i < 32; i++) mem[i] = '0;
        end else begin
            if (out_valid && out_ready) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_pop: outValid with empty scoreboard, rd=%0d", rd);
                end else begin
                    e = sb.pop_front();
                    if ({f3, f7, opi, r1, r2, imm, rd, ill} !==
                        {e.f3, e.f7, e.opi, e.r1, e.r2, e.imm, e.rd, e.ill}) begin
                        $display("FAIL sb_out: got f3=%0h f7=%0h opi=%0b rs1=%h rs2=%h imm=%h rd=%0d ill=%0b, expected f3=%0h f7=%0h opi=%0b rs1=%h rs2=%h imm=%h rd=%0d ill=%0b",
                                 f3, f7, opi, r1, r2, imm, rd, ill,
                                 e.f3, e.f7, e.opi, e.r1, e.r2, e.imm, e.rd, e.ill);
                    end else begin
                        pass_cnt++;
                    end
                end
            end else if (out_valid && sb.size() > 0 && wb_en && wb_addr != 0) begin
                if (wb_addr == sb[0].i1) sb[0].r1 = wb_data;
                if (wb_addr == sb[0].i2) sb[0].r2 = wb_data;
            end
            if (in_valid && in_ready) begin
                e.i1  = instr[19:15];
                e.i2  = instr[24:20];
                e.f3  = instr[14:12];
                e.f7  = instr[31:25];
                e.opi = (instr[6:0] == 7'h13);
                e.ill = (instr[6:0] != 7'h13) && (instr[6:0] != 7'h33);
                e.imm = {{20{instr[31]}}, instr[31:20]};
                e.rd  = instr[11:7];
                e.r1  = (e.i1 == 0) ? 32'd0 : (wb_en && wb_addr == e.i1) ? wb_data : mem[e.i1];
                e.r2  = (e.i2 == 0) ? 32'd0 : (wb_en && wb_addr == e.i2) ? wb_data : mem[e.i2];
                sb.push_back(e);
            end
            if (wb_en && wb_addr != 0) mem[wb_addr] = wb_data;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        instr     = '0;
        out_ready = 1'b1;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        cycle();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #3;
        total_cnt++;
        if ({out_valid, f3, f7, opi, r1, r2, imm, rd, ill} !== '0) begin
            $display("FAIL reset_outputs: got valid=%0b rs1=%h rs2=%h imm=%h rd=%0d, expected all zero",
                     out_valid, r1, r2, imm, rd);
        end else pass_cnt++;
        cycle();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_inready: got %0b expected 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_add();
        write_reg(5'd5, 32'h0000_0010);
        write_reg(5'd6, 32'hFFFF_FFF0);
        in_valid = 1'b1; instr = 32'h006283B3;
        cycle();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, r1, r2, f3, f7, opi, rd} !==
            {1'b1, 32'h10, 32'hFFFF_FFF0, 3'd0, 7'd0, 1'b0, 5'd7}) begin
            $display("FAIL add_x7: got valid=%0b rs1=%h rs2=%h f3=%0h f7=%0h opi=%0b rd=%0d, expected 1 00000010 fffffff0 0 0 0 7",
                     out_valid, r1, r2, f3, f7, opi, rd);
        end else pass_cnt++;
        cycle();
    endtask

    task automatic test_addi_x0();
        in_valid = 1'b1; instr = 32'hFFF00093;
        cycle();
        in_valid = 1'b0;
        total_cnt++;
        if ({opi, imm, r1, rd, ill} !== {1'b1, 32'hFFFF_FFFF, 32'd0, 5'd1, 1'b0}) begin
            $display("FAIL addi_imm: got opi=%0b imm=%h rs1=%h rd=%0d ill=%0b, expected 1 ffffffff 0 1 0",
                     opi, imm, r1, rd, ill);
        end else pass_cnt++;
        write_reg(5'd0, 32'hDEAD_BEEF);
        in_valid = 1'b1; instr = 32'h00000433;
        cycle();
        in_valid = 1'b0;
        total_cnt++;
        if ({r1, r2} !== 64'd0) $display("FAIL x0_read: got rs1=%h rs2=%h expected 0 0", r1, r2);
        else pass_cnt++;
        cycle();
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; instr = 32'h000284B3;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
        cycle();
        in_valid = 1'b0; wb_en = 1'b0;
        total_cnt++;
        if (r1 !== 32'h1234_5678) $display("FAIL bypass_on: got rs1=%h expected 12345678", r1);
        else pass_cnt++;
        total_cnt++;
        if (r1_0 !== 32'h0000_0010) $display("FAIL bypass_off: got rs1=%h expected 00000010", r1_0);
        else pass_cnt++;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] held_r1;
        in_valid = 1'b1; instr = 32'h00628533; out_ready = 1'b0;
        cycle();
        instr = 32'h00000433;
        held_r1 = 32'h1234_5678;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL stall_inready: got %0b expected 0", in_ready);
        else pass_cnt++;
        cycle();
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'hAAAA_5555;
        cycle();
        wb_en = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready, r1, r2, rd} !== {1'b1, 1'b0, held_r1, 32'hAAAA_5555, 5'd10}) begin
            $display("FAIL stall_refresh: got valid=%0b inready=%0b rs1=%h rs2=%h rd=%0d, expected 1 0 12345678 aaaa5555 10",
                     out_valid, in_ready, r1, r2, rd);
        end else pass_cnt++;
        total_cnt++;
        if (r2_0 !== 32'hFFFF_FFF0) $display("FAIL stall_norefresh: got rs2=%h expected fffffff0", r2_0);
        else pass_cnt++;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, rd} !== {1'b1, 5'd8}) $display("FAIL stall_replace: got valid=%0b rd=%0d expected 1 8", out_valid, rd);
        else pass_cnt++;
        cycle();
    endtask

    task automatic test_back_to_back();
        int good = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            instr = {(i % 2 == 1) ? 7'h20 : 7'h00, 5'(i + 1), 5'(i + 3), 3'(i), 5'(i + 11),
                     (i % 2 == 0) ? 7'h13 : 7'h33};
            cycle();
            if (out_valid === 1'b1 && rd === 5'(i + 11)) good++;
        end
        in_valid = 1'b1; instr = 32'h0000_0063;
        cycle();
        in_valid = 1'b0;
        total_cnt++;
        if (good != 8) $display("FAIL stream_order: got %0d in-order valid cycles expected 8", good);
        else pass_cnt++;
        total_cnt++;
        if ({ill, ill0} !== 2'b11) $display("FAIL branch_illegal: got %b expected 11", {ill, ill0});
        else pass_cnt++;
        cycle();
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; instr = 32'h00628533; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, f3, f7, opi, r1, r2, imm, rd, ill} !== '0) begin
            $display("FAIL async_reset: got valid=%0b rs1=%h rs2=%h imm=%h rd=%0d, expected all zero",
                     out_valid, r1, r2, imm, rd);
        end else pass_cnt++;
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'h000285B3;
        cycle();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, r1, rd} !== {1'b1, 32'd0, 5'd11}) begin
            $display("FAIL post_reset_x5: got valid=%0b rs1=%h rd=%0d expected 1 0 11", out_valid, r1, rd);
        end else pass_cnt++;
        cycle();
        cycle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi_x0();
        test_bypass();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL sb_drain: %0d entries left expected 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch stage directly upstream of the integer ALU. Accepts 32-bit OP and OP-IMM instructions over a valid/ready handshake, decodes the ALU control fields and I-type immediate, and reads rs1/rs2 from an embedded 31×32 register file. Outputs are registered and held in a single-entry output stage. A writeback port, driven by the ALU result path, updates the register file and bypasses into both the read path and the held output.

## Interface
- `BYPASS_EN`, 1: enables writeback→read bypass and held-operand refresh; 0 = plain register-file read.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `inValid`  in  1  instruction present.
- `inReady`  out  1  stage can accept this cycle.
- `instruction`  in  32  raw RV32I instruction word.
- `outValid`  out  1  registered outputs hold a decoded instruction.
- `outReady`  in  1  ALU consumer accepts this cycle.
- `funct3`  out  `Funct3_t` (3)  instruction[14:12].
- `funct7`  out  `Funct7_t` (7)  instruction[31:25], for both OP and OP-IMM.
- `opImm`  out  1  1 when opcode = OP-IMM.
- `rs1`  out  32  source-1 operand value.
- `rs2`  out  32  source-2 operand value (read even for OP-IMM).
- `immediateI`  out  32  sign-extended instruction[31:20].
- `rdAddr`  out  5  instruction[11:7].
- `illegal`  out  1  opcode is neither OP (0110011) nor OP-IMM (0010011).
- `wbEnable`  in  1  write `wbData` to `wbAddr` this cycle.
- `wbAddr`  in  5  writeback register index.
- `wbData`  in  32  writeback value.

## Operation
- `inReady = !outValid || outReady` (combinational; no dependency on `inValid`).
- Accept = `inValid && inReady`. On accept: decode fields, read operands, load all output registers, `outValid <= 1`.
- Not accepting and `outReady`: `outValid <= 0`; data registers keep their values.
- Not accepting and not `outReady`: all outputs hold, except held-operand refresh.
- Register file: x1–x31 writable; x0 reads 0 always; writes to x0 are dropped. Writes occur on every cycle with `wbEnable`, independent of the handshake.
- Read bypass (BYPASS_EN=1): if `wbEnable && wbAddr != 0 && wbAddr == rsN index`, the operand captured on accept is `wbData`, not the stale array value.
- Held-operand refresh (BYPASS_EN=1): while `outValid && !outReady`, a writeback matching the held instruction's rs1/rs2 index (≠0) overwrites the held `rs1`/`rs2` output register with `wbData` at the same edge. Source indices of the held instruction are stored internally.
- `illegal` instructions are accepted and decoded like any other; `illegal` is asserted alongside them. Operand values still follow the rules above.
- Reset: `outValid`=0, `funct3`, `funct7`, `opImm`, `rs1`, `rs2`, `immediateI`, `rdAddr`, `illegal` = 0; all 31 registers cleared to 0 asynchronously. `inReady`=1 once reset is deasserted.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible with `outValid` after edge N.
- Throughput is 1 instruction/cycle with `outReady` held high.
- A writeback at edge N is visible to an instruction accepted at edge N through the bypass, and to any later instruction through the array.
- Simultaneous accept and consume: the output is replaced in place and `outValid` stays 1.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge. A pending held instruction is discarded.
- With BYPASS_EN=0, the same-edge case returns the old array value.

## Structure
- The shared core package holds:
  - `Funct3_t` and `Funct7_t`, already used by the ALU.
  - `OPCODE_OP` and `OPCODE_OP_IMM` constants.
  - A `RegIndex_t` 5-bit typedef.
- Sub-module `register_file`:
  - 2 asynchronous read ports, 1 synchronous write port, asynchronous clear, x0 hardwired.
  - Bypass and refresh logic live in `operand_fetch`, not in `register_file`.

## Test plan
- Reset, then write x5=0x0000_0010 and x6=0xFFFF_FFF0; feed `add x7,x5,x6` (0x006283B3). Next cycle expect `outValid`=1, `rs1`=0x10, `rs2`=0xFFFF_FFF0, `funct3`=0, `funct7`=0, `opImm`=0, `rdAddr`=7.
- Feed `addi x1,x0,-1` (0xFFF00093). Expect `opImm`=1, `immediateI`=0xFFFF_FFFF, `rs1`=0. Separately, `wbEnable` to x0 with 0xDEAD_BEEF, then read x0: expect 0.
- Same-edge bypass: accept an instruction reading x5 while `wbEnable`, `wbAddr`=5, `wbData`=0x1234_5678. Expect `rs1`=0x1234_5678. Repeat with BYPASS_EN=0: expect the old value.
- Backpressure: hold `outReady`=0 for 3 cycles with an instruction reading x6 held. Write x6=0xAAAA_5555 during the stall. Expect `inReady`=0, outputs otherwise stable, `rs2` updated to 0xAAAA_5555 the following cycle.
- Streaming: 8 back-to-back instructions with `outReady`=1. Expect 8 consecutive `outValid` cycles in order, with no bubbles. Feed opcode 0x0000_0063 (branch): expect `illegal`=1.
- Assert `reset` mid-stall between clock edges. Expect `outValid`=0 and all outputs 0 immediately; a subsequent read of x5 returns 0.
